// File: rtl/gear_approx_adder_8bit.sv
`default_nettype none
// ============================================================================
// Module      : gear_approx_adder_8bit
// Description : Registered GeAr (Generic Accuracy-configurable) approximate
//               adder. The N-bit addition is split into K overlapping
//               sub-adders of length L=R+P, each with carry-in 0. The low P
//               bits of every sub-adder only predict its carry; the high R
//               bits form part of the sum. Also flags results that differ
//               from the exact sum.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset
//               in_valid  - operands valid this cycle
//               a, b      - N-bit unsigned operands
//               out_valid - registered result valid
//               sum       - registered N+1 bit approximate sum
//               err       - registered flag, 1 when sum != a+b
// Revision    : 1.0 - initial release
// ============================================================================
module gear_approx_adder_8bit #(
    parameter int N = 8,
    parameter int R = 2,
    parameter int P = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N:0]   sum,
    output logic         err
);

    localparam int c_L = R + P;
    localparam int c_K = (N - c_L) / R + 1;

    // Reject illegal configurations at elaboration time.
    generate
        if ((R < 1) || (P < 0) || (c_L > N) || (((N - c_L) % R) != 0)) begin : g_illegal_cfg
            $error("gear_approx_adder_8bit: illegal N/R/P configuration");
        end
    endgenerate

    // Each sub-adder result carries one extra bit for its carry-out.
    logic [c_L:0] w_sub [c_K];
    logic [N:0]   w_approx;
    logic [N:0]   w_exact;
    logic         w_err;

    generate
        for (genvar j = 0; j < c_K; j++) begin : g_sub
            assign w_sub[j] = {1'b0, a[j*R + c_L - 1 : j*R]}
                            + {1'b0, b[j*R + c_L - 1 : j*R]};

            if (j == 0) begin : g_first
                // The first sub-adder has no predecessor, so all of its
                // bits are trusted.
                assign w_approx[c_L-1:0] = w_sub[j][c_L-1:0];
            end else begin : g_rest
                // Only the upper R bits are kept; the low P bits merely
                // served to guess the carry into this window.
                assign w_approx[j*R + c_L - 1 : j*R + P] = w_sub[j][c_L-1:P];
            end
        end
    endgenerate

    // Carry-out of the last sub-adder is the MSB; all other carries drop.
    assign w_approx[N] = w_sub[c_K-1][c_L];

    // Errors only ever drop carries, so any difference is a real error.
    assign w_exact = {1'b0, a} + {1'b0, b};
    assign w_err   = (w_approx != w_exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            err       <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            sum       <= w_approx;
            err       <= w_err;
        end else begin
            // Result registers hold; only the valid flag drops.
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gear_approx_adder_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_gear_approx_adder_8bit
// Description : Self-checking bench for gear_approx_adder_8bit. Directed
//               cases, an exhaustive operand sweep and random streaming are
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gear_approx_adder_8bit;

    localparam int c_N = 8;
    localparam int c_R = 2;
    localparam int c_P = 2;
    localparam int c_L = c_R + c_P;
    localparam int c_K = (c_N - c_L) / c_R + 1;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [c_N-1:0] a;
    logic [c_N-1:0] b;
    logic           out_valid;
    logic [c_N:0]   sum;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;

    gear_approx_adder_8bit #(
        .N (c_N),
        .R (c_R),
        .P (c_P)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (a=0x%0h b=0x%0h)",
                     tag, got, exp, a, b);
        end
    endtask

    // Sum of the operand window of sub-adder j, computed as plain integers.
    function automatic int window_sum(input int x, input int y, input int j);
        int m;
        m = 1 << c_L;
        return ((x >> (j * c_R)) % m) + ((y >> (j * c_R)) % m);
    endfunction

    // Approximate sum built from the window rules with integer arithmetic.
    function automatic int model_sum(input int x, input int y);
        int res;
        int s;
        res = window_sum(x, y, 0) % (1 << c_L);
        for (int j = 1; j < c_K; j++) begin
            s   = window_sum(x, y, j) % (1 << c_L);
            res = res + ((s >> c_P) << (j * c_R + c_P));
        end
        res = res + ((window_sum(x, y, c_K - 1) >> c_L) << c_N);
        return res;
    endfunction

    // Drive one operand pair (or an idle cycle) and sample after the edge.
    task automatic step(input logic v, input int x, input int y);
        @(negedge clk);
        in_valid = v;
        a        = c_N'(x);
        b        = c_N'(y);
        @(posedge clk);
        #1;
    endtask

    // Apply a valid pair and check it against the model and invariants.
    task automatic run_model(input int x, input int y, input string tag);
        int exp_sum;
        int exact;
        step(1'b1, x, y);
        exp_sum = model_sum(x, y);
        exact   = x + y;
        check_val({tag, "_vld"}, int'(out_valid), 1);
        check_val({tag, "_sum"}, int'(sum), exp_sum);
        check_val({tag, "_err"}, int'(err), int'(exp_sum != exact));
        check_val({tag, "_le"}, int'(int'(sum) <= exact), 1);
        check_val({tag, "_msb"}, int'(sum[c_N]), window_sum(x, y, c_K - 1) >> c_L);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;

        // Reset dominates a valid operand pair.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_vld", int'(out_valid), 0);
        check_val("rst_sum", int'(sum), 0);
        check_val("rst_err", int'(err), 0);

        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_vld", int'(out_valid), 0);

        // Directed cases with hand-derived results.
        step(1'b1, 8'h0F, 8'h01);
        check_val("d0f01_vld", int'(out_valid), 1);
        check_val("d0f01_sum", int'(sum), 9'h000);
        check_val("d0f01_err", int'(err), 1);

        step(1'b1, 8'hFF, 8'h01);
        check_val("dff01_sum", int'(sum), 9'h0F0);
        check_val("dff01_err", int'(err), 1);

        step(1'b1, 8'hFF, 8'hFF);
        check_val("dffff_sum", int'(sum), 9'h1FE);
        check_val("dffff_err", int'(err), 0);

        step(1'b0, 8'h12, 8'h34);
        check_val("hold1_vld", int'(out_valid), 0);
        check_val("hold1_sum", int'(sum), 9'h1FE);
        check_val("hold1_err", int'(err), 0);

        step(1'b1, 8'h55, 8'hAA);
        check_val("d55aa_sum", int'(sum), 9'h0FF);
        check_val("d55aa_err", int'(err), 0);

        // Back-to-back stream followed by an idle cycle.
        step(1'b1, 8'h06, 8'h02);
        check_val("s0_vld", int'(out_valid), 1);
        check_val("s0_sum", int'(sum), 9'h008);
        check_val("s0_err", int'(err), 0);
        step(1'b1, 8'h0F, 8'h01);
        check_val("s1_vld", int'(out_valid), 1);
        check_val("s1_sum", int'(sum), 9'h000);
        check_val("s1_err", int'(err), 1);
        step(1'b0, 8'hAB, 8'hCD);
        check_val("hold2_vld", int'(out_valid), 0);
        check_val("hold2_sum", int'(sum), 9'h000);
        check_val("hold2_err", int'(err), 1);

        // Exhaustive operand sweep.
        for (int x = 0; x < (1 << c_N); x++) begin
            for (int y = 0; y < (1 << c_N); y++) begin
                run_model(x, y, "swp");
            end
        end

        // Random stream with random idle cycles and mid-stream reset.
        for (int i = 0; i < 1500; i++) begin
            int x;
            int y;
            int last_sum;
            int last_err;
            x = int'($urandom_range(255, 0));
            y = int'($urandom_range(255, 0));
            if ($urandom_range(7, 0) == 0) begin
                last_sum = int'(sum);
                last_err = int'(err);
                step(1'b0, x, y);
                check_val("rnd_idle_vld", int'(out_valid), 0);
                check_val("rnd_idle_sum", int'(sum), last_sum);
                check_val("rnd_idle_err", int'(err), last_err);
            end else if (i == 700) begin
                @(negedge clk);
                rst      = 1'b1;
                in_valid = 1'b1;
                a        = c_N'(x);
                b        = c_N'(y);
                @(posedge clk);
                #1;
                rst = 1'b0;
                check_val("rnd_rst_vld", int'(out_valid), 0);
                check_val("rnd_rst_sum", int'(sum), 0);
                check_val("rnd_rst_err", int'(err), 0);
            end else begin
                run_model(x, y, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gear_approx_adder_8bit.md
Name: gear_approx_adder_8bit

Overview:
- Registered Generic Accuracy-configurable (GeAr) approximate adder. Default configuration is 8-bit.
- Splits the N-bit addition into overlapping sub-adders of length L=R+P. Each sub-adder:
  - starts with carry-in 0;
  - uses its P low bits only to predict the carry;
  - contributes its R high result bits to the sum.
- Used as the approximate-arithmetic datapath element in error-characterisation and low-power accumulator experiments.
- Also flags cycles whose approximate result differs from the exact sum.

Parameters:
- N, 8, operand width in bits.
- R, 2, result bits contributed per sub-adder.
- P, 2, carry-prediction (overlap) bits per sub-adder.
- Legality:
  - R>=1, P>=0, R+P<=N, and (N-R-P) divisible by R.
  - Elaboration fails (generate-time error) otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid this cycle.
- a  input  N  operand A, unsigned.
- b  input  N  operand B, unsigned.
- out_valid  output  1  registered; result valid.
- sum  output  N+1  registered approximate sum, unsigned.
- err  output  1  registered; 1 when sum != a+b (exact).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: on a clk edge with rst=1, out_valid=0, sum=0, err=0. Reset dominates in_valid. An operand presented in the reset cycle is discarded.
- Latency: 1 cycle. Operands sampled at edge k appear on sum/err with out_valid=1 after edge k.
  - No backpressure; back-to-back inputs every cycle are accepted.
- in_valid=0 at an edge: out_valid<=0; sum and err hold their previous values.
- Sub-adder structure:
  - Number of sub-adders K=(N-L)/R+1, where L=R+P.
  - Sub-adder j (0..K-1) adds a[jR+L-1:jR] + b[jR+L-1:jR] with carry-in 0, giving an L-bit result s_j and carry-out c_j.
- Sum assembly:
  - sum[L-1:0] = s_0 (sub-adder 0 contributes all L bits).
  - For j>=1: sum[jR+L-1 : jR+P] = s_j[L-1:P].
  - sum[N] = c_{K-1}. Carries of all other sub-adders are discarded.
- Default (N=8,R=2,P=2): K=3 sub-adders.
  - Sub-adder 0 covers bits[3:0] and drives sum[3:0].
  - Sub-adder 1 covers bits[5:2] and drives sum[5:4].
  - Sub-adder 2 covers bits[7:4] and drives sum[7:6] plus sum[8].
- Error flag:
  - err=1 iff some j>=1 has (a^b) all ones over bits [jR+P-1:jR] and the exact carry into bit jR is 1.
  - This is equivalent to sum != exact a+b.
  - Approximation errors only drop carries, so approx <= exact always and errors never cancel.
  - Implementation may use either the detection form or an exact comparison. The registered result must match the equivalence.
- When P>=N-R (K=1), the adder is exact and err is constantly 0.
- All arithmetic is unsigned; no overflow is possible since sum is N+1 bits.

Test Plan:
- Reset: hold rst=1 with in_valid=1, a=0xFF, b=0xFF -> out_valid=0, sum=0, err=0. Release rst; next valid result appears 1 cycle after sampling.
- a=0x0F, b=0x01, in_valid=1 -> next cycle sum=0x000, err=1 (exact 16; error -16).
- a=0xFF, b=0x01 -> sum=0x0F0 (240), err=1 (exact 256).
- a=0xFF, b=0xFF -> sum=0x1FE (510), err=0. Also a=0x55, b=0xAA -> sum=0x0FF, err=0.
- Streaming and hold:
  - Apply (0x06,0x02) then (0x0F,0x01) on consecutive cycles -> sum=0x008/err=0, then sum=0x000/err=1.
  - Then in_valid=0 -> out_valid=0, sum stays 0x000, err stays 1.
- Exhaustive 256x256 sweep against the bit-level sub-adder reference model -> every sum matches the model, err==(sum!=a+b), sum<=a+b always, and sum[8] equals sub-adder 2's carry-out.
